// File: rtl/mem_responder_if.sv
// Bus between the multicycle controller/datapath and the memory responder.
// The master drives the strobes, address and write data; the slave returns data and status.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_ready;
    logic              mem_busy;
    logic              err;

    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, mem_ready, mem_busy, err
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, mem_ready, mem_busy, err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: one access at a time, WAIT_STATES wait cycles, then a one-cycle mem_ready.
// Optional macro MEMRESP_RANGE_CHECK_EN turns addresses at or above DEPTH into error completions instead of wrapping.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus
);
    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              isRead_q, isRead_d;
    logic              isWrite_q, isWrite_d;
    logic              isErr_q, isErr_d;
    logic              enterDone;
    logic              request;
    logic              reqErr;
    logic              rangeErr;

    logic [DATA_W-1:0] mem [DEPTH];

    assign request = bus.MemRead | bus.MemWrite;

`ifdef MEMRESP_RANGE_CHECK_EN
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    assign rangeErr = ({1'b0, bus.addr} >= DEPTH_EXT);
`else
    assign rangeErr = 1'b0;
    if (IDX_W < ADDR_W) begin : g_addrHi
        logic unusedAddrBits;
        assign unusedAddrBits = ^bus.addr[ADDR_W-1:IDX_W];
    end
`endif

    assign reqErr = (bus.MemRead & bus.MemWrite) | rangeErr;

    // The _d copies of the latched request double as the access operands on the edge entering DONE,
    // which covers both the zero-wait path straight from IDLE and the end of ACCESS.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        isRead_d  = isRead_q;
        isWrite_d = isWrite_q;
        isErr_d   = isErr_q;
        enterDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (request) begin
                    idx_d     = bus.addr[IDX_W-1:0];
                    wdata_d   = bus.wdata;
                    isRead_d  = bus.MemRead;
                    isWrite_d = bus.MemWrite;
                    isErr_d   = reqErr;
                    cnt_d     = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        state_d   = DONE;
                        enterDone = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = DONE;
                    enterDone = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdata_d = rdata_q;
        if (enterDone && isRead_d && !isErr_d) begin
            rdata_d = mem[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            isRead_q  <= 1'b0;
            isWrite_q <= 1'b0;
            isErr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            isRead_q  <= isRead_d;
            isWrite_q <= isWrite_d;
            isErr_q   <= isErr_d;
        end
    end

    // Storage survives reset, but a reset on the committing edge still discards the write.
    always_ff @(posedge clk) begin
        if (!rst && enterDone && isWrite_d && !isErr_d) begin
            mem[idx_d] <= wdata_d;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_ready = (state_q == DONE);
    assign bus.mem_busy  = (state_q != IDLE);
    assign bus.err       = (state_q == DONE) && isErr_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array reference model.
// A second instance with zero wait states covers back-to-back completions under a held strobe.
module tb_mem_responder;
    localparam int WS    = 2;
    localparam int DEPTH = 256;

    logic clk;
    logic rst;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [15:0] refMem [DEPTH];
    logic [15:0] refRdata;
    logic [15:0] ref0 [4];

    mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus  ();
    mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();

    mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expectQuiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("quiet_ready", {31'd0, bus.mem_ready}, 32'd0);
        end
    endtask

    // One full transaction: drive the request, optionally poke a write while busy, then check the completion.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a,
                                 input logic [15:0] d, input bit poke);
        bit expErr;
        bit seen;
        int lat;
        int busyCnt;
        int idx;
        idx    = int'(a) % DEPTH;
        expErr = rd && wr;
`ifdef MEMRESP_RANGE_CHECK_EN
        if (int'(a) >= DEPTH) expErr = 1'b1;
`endif
        @(negedge clk);
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.addr     = a;
        bus.wdata    = d;
        @(posedge clk);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        seen    = 1'b0;
        lat     = 0;
        busyCnt = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (poke && i == 2) bus.MemWrite = 1'b0;
            if (bus.mem_busy) busyCnt++;
            if (bus.mem_ready) begin
                seen = 1'b1;
                lat  = i;
            end
            if (poke && i == 1) begin
                bus.MemWrite = 1'b1;
                bus.wdata    = ~d;
            end
        end
        bus.MemWrite = 1'b0;
        checkOutput("ready_seen", {31'd0, seen}, 32'd1);
        if (!expErr) begin
            if (wr) refMem[idx] = d;
            if (rd) refRdata = refMem[idx];
        end
        checkOutput("latency", lat, WS + 1);
        checkOutput("busy_cycles", busyCnt, WS + 1);
        checkOutput("err", {31'd0, bus.err}, {31'd0, expErr});
        checkOutput("rdata", {16'd0, bus.rdata}, {16'd0, refRdata});
        @(negedge clk);
        checkOutput("after_ready", {30'd0, bus.mem_ready, bus.mem_busy}, 32'd0);
        checkOutput("after_err", {31'd0, bus.err}, 32'd0);
        checkOutput("rdata_held", {16'd0, bus.rdata}, {16'd0, refRdata});
        if (poke) expectQuiet(WS + 2);
    endtask

    task automatic resetMidWrite(input logic [15:0] a);
        logic [15:0] d;
        d = ~refMem[int'(a) % DEPTH];
        @(negedge clk);
        bus.MemWrite = 1'b1;
        bus.addr     = a;
        bus.wdata    = d;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", {31'd0, bus.mem_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        refRdata = 16'd0;
        checkOutput("midrst_state", {29'd0, bus.mem_ready, bus.mem_busy, bus.err}, 32'd0);
        checkOutput("midrst_rdata", {16'd0, bus.rdata}, 32'd0);
        expectQuiet(WS + 3);
    endtask

    initial begin
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus0.MemRead  = 1'b0;
        bus0.MemWrite = 1'b0;
        bus0.addr     = '0;
        bus0.wdata    = '0;

        rst          = 1'b1;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b1;
        bus0.MemRead = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_flags", {29'd0, bus.mem_ready, bus.mem_busy, bus.err}, 32'd0);
        checkOutput("reset_rdata", {16'd0, bus.rdata}, 32'd0);
        checkOutput("reset0_flags", {29'd0, bus0.mem_ready, bus0.mem_busy, bus0.err}, 32'd0);
        rst          = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus0.MemRead = 1'b0;
        refRdata     = 16'd0;
        expectQuiet(2);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 16'(i), 16'($urandom), 1'b0);
        end

        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
        checkOutput("beef_read", {16'd0, bus.rdata}, 32'h0000BEEF);

        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h1234, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);

        applyStimulus(1'b1, 1'b1, 16'h0005, 16'hFFFF, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'h0105, 16'hA5C3, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);

        resetMidWrite(16'h0033);
        applyStimulus(1'b1, 1'b0, 16'h0033, 16'h0000, 1'b0);

        for (int i = 0; i < 60; i++) begin
            int          sel;
            logic [15:0] a;
            sel = int'($urandom_range(0, 9));
            a   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, DEPTH - 1)) : 16'($urandom);
            case (sel)
                0, 1, 2, 3: applyStimulus(1'b1, 1'b0, a, 16'($urandom), 1'b0);
                4, 5, 6, 7: applyStimulus(1'b0, 1'b1, a, 16'($urandom), 1'b0);
                8:          applyStimulus(1'b1, 1'b1, a, 16'($urandom), 1'b0);
                default:    applyStimulus(1'b1, 1'b0, a, 16'($urandom), 1'b1);
            endcase
        end

        // Zero-wait instance: preload four words, then hold MemRead and expect a pulse every second cycle.
        for (int i = 0; i < 4; i++) begin
            ref0[i] = 16'($urandom);
            @(negedge clk);
            bus0.MemWrite = 1'b1;
            bus0.addr     = 16'(i);
            bus0.wdata    = ref0[i];
            @(posedge clk);
            #1;
            bus0.MemWrite = 1'b0;
            @(negedge clk);
            checkOutput("ws0_write_ready", {31'd0, bus0.mem_ready}, 32'd1);
        end
        @(negedge clk);
        bus0.MemRead = 1'b1;
        bus0.addr    = 16'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                checkOutput("ws0_ready_hi", {31'd0, bus0.mem_ready}, 32'd1);
                checkOutput("ws0_rdata", {16'd0, bus0.rdata}, {16'd0, ref0[i / 2]});
                bus0.addr = 16'((i / 2 + 1) % 4);
            end else begin
                checkOutput("ws0_ready_lo", {31'd0, bus0.mem_ready}, 32'd0);
            end
        end
        bus0.MemRead = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
